// File: rtl/store_word_unit.sv
// store_word_unit: executes MIPS "sw rt, imm(rs)" one instruction at a time.
// An accepted instruction walks IDLE -> DECODE -> EXEC -> MEM and either
// commits rf[rt] to the word-addressed data memory (done pulse) or is
// rejected without touching memory (fault pulse with a reason code).
module store_word_unit #(
  parameter int DM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        rf_we,
  input  logic [4:0]  rf_wa,
  input  logic [31:0] rf_wd,
  input  logic [5:0]  dm_ra,
  output logic [31:0] dm_rd,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam int         DATA_W    = 32;
  localparam int         AW        = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [1:0] FC_NONE   = 2'b00;
  localparam logic [1:0] FC_OPCODE = 2'b01;
  localparam logic [1:0] FC_ALIGN  = 2'b10;
  localparam logic [1:0] FC_RANGE  = 2'b11;

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, MEM} state_t;

  state_t state, state_nxt;

  // Architectural storage; neither array is touched by reset.
  logic [DATA_W-1:0] rf [32];
  logic [DATA_W-1:0] dm [DM_WORDS];

  logic               hs;
  logic [DATA_W-1:0]  instr_p0;
  logic signed [DATA_W-1:0] rs_val_p1;
  logic signed [DATA_W-1:0] imm_p1;
  logic [DATA_W-1:0]  rt_val_p1;
  logic [DATA_W-1:0]  addr_p2;
  logic [DATA_W-1:0]  wdata_p2;
  logic [DATA_W-1:0]  rs_rd;
  logic [DATA_W-1:0]  rt_rd;
  logic [1:0]         mem_chk;
  logic [AW-1:0]      wr_idx;
  logic [AW-1:0]      rd_idx;

  wire [5:0] op_p0 = instr_p0[31:26];
  wire [4:0] rs_p0 = instr_p0[25:21];
  wire [4:0] rt_p0 = instr_p0[20:16];

  // Sign-extend the 16-bit displacement to a full word.
  function automatic logic signed [DATA_W-1:0] sext_imm(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  // Classify a byte address: misalignment wins over the range check.
  function automatic logic [1:0] addr_check(input logic [DATA_W-1:0] addr);
    if (addr[1:0] != 2'b00) return FC_ALIGN;
    if ({2'b00, addr[31:2]} >= 32'(DM_WORDS)) return FC_RANGE;
    return FC_NONE;
  endfunction

  assign hs      = instr_valid && instr_ready;
  assign rs_rd   = (rs_p0 == 5'd0) ? '0 : rf[rs_p0];
  assign rt_rd   = (rt_p0 == 5'd0) ? '0 : rf[rt_p0];
  assign mem_chk = addr_check(addr_p2);
  assign wr_idx  = addr_p2[AW+1:2];
  assign rd_idx  = AW'(dm_ra);

  // State register; reset forces IDLE and drops any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: a bad opcode short-circuits back to IDLE from DECODE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = DECODE;
      DECODE:  state_nxt = (op_p0 == OP_SW) ? EXEC : IDLE;
      EXEC:    state_nxt = MEM;
      MEM:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore-style outputs; ready is withheld while reset is asserted.
  always_comb begin
    busy        = (state != IDLE);
    instr_ready = (state == IDLE) && !reset;
  end

  // Register-file preload, only honoured while idle; r0 is hard-wired to zero.
  always_ff @(posedge clk) begin
    if (state == IDLE && rf_we && rf_wa != 5'd0) rf[rf_wa] <= rf_wd;
  end

  // ---- p0: instruction capture on handshake ----
  // Latch the offered instruction word.
  always_ff @(posedge clk) begin
    if (hs) instr_p0 <= instr;
  end

  // ---- p1: DECODE, operand fetch ----
  // Capture both source registers and the extended displacement.
  always_ff @(posedge clk) begin
    if (state == DECODE) begin
      rs_val_p1 <= rs_rd;
      rt_val_p1 <= rt_rd;
      imm_p1    <= sext_imm(instr_p0[15:0]);
    end
  end

  // ---- p2: EXEC, effective address ----
  // Wrap-around address add; carry out of bit 31 is dropped.
  always_ff @(posedge clk) begin
    if (state == EXEC) begin
      addr_p2  <= rs_val_p1 + imm_p1;
      wdata_p2 <= rt_val_p1;
    end
  end

  // ---- MEM: commit ----
  // Memory write, suppressed by reset or by an address fault.
  always_ff @(posedge clk) begin
    if (!reset && state == MEM && mem_chk == FC_NONE) dm[wr_idx] <= wdata_p2;
  end

  // Completion/fault pulses; fault_code is sticky until the next fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      done       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      if (state == DECODE && op_p0 != OP_SW) begin
        fault      <= 1'b1;
        fault_code <= FC_OPCODE;
      end else if (state == MEM) begin
        if (mem_chk == FC_NONE) begin
          done <= 1'b1;
        end else begin
          fault      <= 1'b1;
          fault_code <= mem_chk;
        end
      end
    end
  end

  // Inspection port; indices beyond the memory read as zero.
  always_comb begin
    dm_rd = '0;
    if ({26'b0, dm_ra} < 32'(DM_WORDS)) dm_rd = dm[rd_idx];
  end

endmodule
